// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// mem_bus_ctrl : CPU bus decoder with byte-lane RAM, LED register and UART TX
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_bus_ctrl #(
    parameter int RAM_WORDS = 1024,
    parameter int BAUD_DIV  = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic [7:0]  led,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    logic [31:0]   ram [RAM_WORDS];
    uart_state_t   state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_data;

    logic          is_io;
    logic [AW-1:0] ram_idx;
    logic [5:0]    io_idx;
    logic          io_wr;
    logic          uart_wr;
    logic          busy;
    logic          baud_last;
    logic          tx_level;
    logic [31:0]   io_rdata;
    logic          unused_addr;

    assign is_io       = mem_addr[22];
    assign ram_idx     = mem_addr[AW+1:2];
    assign io_idx      = mem_addr[7:2];
    assign io_wr       = rst && is_io && mem_wstrb[0];
    assign uart_wr     = io_wr && (io_idx == 6'd1) && (state == IDLE);
    assign busy        = (state != IDLE);
    assign baud_last   = (baud_cnt == BAUD_LAST);
    assign unused_addr = ^mem_addr;

    always_comb begin
        io_rdata = 32'd0;
        case (io_idx)
            6'd0:    io_rdata = {24'd0, led};
            6'd2:    io_rdata = {31'd0, busy};
            default: io_rdata = 32'd0;
        endcase
    end

    always_comb begin
        tx_level = 1'b1;
        case (state)
            START:   tx_level = 1'b0;
            DATA:    tx_level = tx_data[bit_idx];
            default: tx_level = 1'b1;
        endcase
    end

    // RAM contents survive reset; only the write enable is gated by it.
    always_ff @(posedge clk) begin
        if (rst && !is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) begin
                    ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_rdata <= 32'd0;
            led       <= 8'd0;
            uart_tx   <= 1'b1;
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            tx_data   <= 8'd0;
        end else begin
            // The RAM read samples the word before this edge's write lands.
            if (mem_rstrb) begin
                mem_rdata <= is_io ? io_rdata : ram[ram_idx];
            end
            if (io_wr && (io_idx == 6'd0)) begin
                led <= mem_wdata[7:0];
            end

            uart_tx <= tx_level;

            case (state)
                IDLE: begin
                    if (uart_wr) begin
                        tx_data  <= mem_wdata[7:0];
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
